// File: rtl/strait_pkg.sv
// Shared defaults and state encoding for the STRAIT systolic datapath blocks.
package strait_pkg;

    localparam int DEF_SYSTOLIC_SIZE    = 8;
    localparam int DEF_ACTIVATION_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } act_state_e;

endpackage

// File: rtl/activation_mem_array.sv
// Activation vector storage: one write port, one synchronous read port, read-before-write.
// The read register clears to zero whenever no read is requested.
module activation_mem_array #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset so it maps onto RAM; only the write is gated during reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments give read-before-write when addresses collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/activation_mem.sv
// Streams stored activation vectors 0..length-1 to the systolic array, one per cycle.
// Define ACTIVATION_MEM_ZERO_FLUSH_EN to append SYSTOLIC_SIZE-1 zero vectors to each run.
module activation_mem
    import strait_pkg::*;
#(
    parameter  int SYSTOLIC_SIZE    = DEF_SYSTOLIC_SIZE,
    parameter  int ACTIVATION_WIDTH = DEF_ACTIVATION_WIDTH,
    parameter  int DEPTH            = 16,
    localparam int AW               = $clog2(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wr_en,
    input  logic [AW-1:0]                         wr_addr,
    input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] wr_data_flat,
    input  logic                                  start,
    input  logic [AW:0]                           length,
    output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] activation_out_flat,
    output logic                                  act_valid,
    output logic                                  busy,
    output logic                                  done
);

    localparam int         VW        = SYSTOLIC_SIZE * ACTIVATION_WIDTH;
    localparam logic [AW:0] DEPTH_LEN = (AW + 1)'(DEPTH);

    act_state_e      state;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [AW:0]     len_c;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;

`ifdef ACTIVATION_MEM_ZERO_FLUSH_EN
    localparam int FLUSH_CYCLES = SYSTOLIC_SIZE - 1;
    localparam int FW           = $clog2(SYSTOLIC_SIZE + 1);
    logic [FW-1:0] flush_cnt;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        len_c   = (length > DEPTH_LEN) ? DEPTH_LEN : length;
        rd_en   = 1'b0;
        rd_addr = rd_ptr;
        case (state)
            IDLE: begin
                rd_en   = start && (len_c != '0);
                rd_addr = '0;
            end
            STREAM:  rd_en = (count != '0);
            default: rd_en = 1'b0;
        endcase
    end

    activation_mem_array #(
        .WIDTH (VW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data_flat),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (activation_out_flat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            count     <= '0;
            act_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef ACTIVATION_MEM_ZERO_FLUSH_EN
            flush_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_c != '0) begin
                            state     <= STREAM;
                            act_valid <= 1'b1;
                            busy      <= 1'b1;
                            rd_ptr    <= AW'(1);
                            count     <= len_c - 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (count != '0) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        count  <= count - 1'b1;
                    end else begin
`ifdef ACTIVATION_MEM_ZERO_FLUSH_EN
                        if (FLUSH_CYCLES > 0) begin
                            // act_valid stays high; the array register clears to a zero vector.
                            state     <= FLUSH;
                            flush_cnt <= FW'(FLUSH_CYCLES - 1);
                        end else begin
                            state     <= DONE;
                            act_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
`else
                        state     <= DONE;
                        act_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
`endif
                    end
                end
`ifdef ACTIVATION_MEM_ZERO_FLUSH_EN
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state     <= DONE;
                        act_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    act_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_activation_mem.sv
// Directed bench for activation_mem at SYSTOLIC_SIZE=8, ACTIVATION_WIDTH=8, DEPTH=16.
// Expectations adapt to whether ACTIVATION_MEM_ZERO_FLUSH_EN is defined.
module tb_activation_mem;

    localparam int N     = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int W     = 64;
`ifdef ACTIVATION_MEM_ZERO_FLUSH_EN
    localparam int FLUSH_N = N - 1;
`else
    localparam int FLUSH_N = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data_flat;
    logic          start;
    logic [AW:0]   length;
    logic [W-1:0]  activation_out_flat;
    logic          act_valid;
    logic          busy;
    logic          done;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] model [DEPTH];

    always #5 clk = ~clk;

    activation_mem #(
        .SYSTOLIC_SIZE    (N),
        .ACTIVATION_WIDTH (8),
        .DEPTH            (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .wr_data_flat        (wr_data_flat),
        .start               (start),
        .length              (length),
        .activation_out_flat (activation_out_flat),
        .act_valid           (act_valid),
        .busy                (busy),
        .done                (done)
    );

    function automatic logic [W-1:0] pattern(input int a);
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) v[i*8 +: 8] = 8'(a * 16 + i);
        return v;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input int a, input logic [W-1:0] d);
        wr_en        = 1'b1;
        wr_addr      = AW'(a);
        wr_data_flat = d;
        step();
        wr_en        = 1'b0;
        model[a]     = d;
    endtask

    // One full run from start to the idle cycle after done, with an optional
    // write in cycle wr_cyc and an optional extra start pulse in cycle restart_cyc.
    task automatic run(input string name, input int req_len, input int wr_cyc, input int wr_a,
                       input logic [W-1:0] wr_d, input int restart_cyc);
        int           n_vec;
        int           fl;
        int           last;
        int           t;
        logic [W-1:0] exp_next;
        logic         e_valid, e_busy, e_done;
        logic [W-1:0] e_data;
        n_vec = (req_len > DEPTH) ? DEPTH : req_len;
        fl    = (n_vec == 0) ? 0 : FLUSH_N;
        last  = n_vec + fl + 1;
        for (int c = 0; c <= last; c++) begin
            start        = (c == 0) || (c == restart_cyc);
            length       = (c == 0) ? (AW + 1)'(req_len) : 5'd2;
            wr_en        = (c == wr_cyc);
            wr_addr      = AW'(wr_a);
            wr_data_flat = wr_d;
            exp_next     = (c < n_vec) ? model[c] : '0;
            if (c == wr_cyc) model[wr_a] = wr_d;
            step();
            start = 1'b0;
            wr_en = 1'b0;
            t = c + 1;
            e_valid = (t <= n_vec + fl);
            e_busy  = (t <= n_vec + fl);
            e_done  = (t == last);
            e_data  = (t <= n_vec) ? exp_next : '0;
            check($sformatf("%s c%0d act_valid", name, t), W'(act_valid), W'(e_valid));
            check($sformatf("%s c%0d data", name, t), activation_out_flat, e_data);
            check($sformatf("%s c%0d busy", name, t), W'(busy), W'(e_busy));
            check($sformatf("%s c%0d done", name, t), W'(done), W'(e_done));
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data_flat = '0;
        start        = 1'b0;
        length       = '0;
        step();
        step();
        check("reset act_valid", W'(act_valid), '0);
        check("reset data", activation_out_flat, '0);
        check("reset busy", W'(busy), '0);
        check("reset done", W'(done), '0);
        rst_n = 1'b1;
        step();

        for (int a = 0; a < DEPTH; a++) write_vec(a, pattern(a));

        run("len4", 4, -1, 0, '0, -1);
        run("len0", 0, -1, 0, '0, -1);
        run("len1", 1, -1, 0, '0, -1);
        run("len20", 20, -1, 0, '0, -1);
        run("rbw", 4, 2, 2, {W{1'b1}}, -1);
        run("rerun", 4, -1, 0, '0, -1);
        write_vec(2, pattern(2));
        run("restart", 4, -1, 0, '0, 3);

        // Reset in cycle 2 of a run; a write during reset must be dropped.
        start  = 1'b1;
        length = 5'd4;
        step();
        start = 1'b0;
        check("abort c1 data", activation_out_flat, model[0]);
        step();
        check("abort c2 data", activation_out_flat, model[1]);
        rst_n        = 1'b0;
        wr_en        = 1'b1;
        wr_addr      = '0;
        wr_data_flat = {W{1'b1}};
        step();
        rst_n = 1'b1;
        wr_en = 1'b0;
        check("abort c3 act_valid", W'(act_valid), '0);
        check("abort c3 data", activation_out_flat, '0);
        check("abort c3 busy", W'(busy), '0);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("abort idle%0d done", k), W'(done), '0);
            check($sformatf("abort idle%0d act_valid", k), W'(act_valid), '0);
            step();
        end
        run("postrst", 1, -1, 0, '0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/activation_mem.md
ACTIVATION_MEM -- requirements
Module: activation_mem

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8, meaning number of activation lanes (systolic rows).
REQ-002 SHALL have parameter ACTIVATION_WIDTH, default 8, meaning bits per activation lane.
REQ-003 SHALL have parameter DEPTH, default 16, meaning number of stored activation vectors; AW = clog2(DEPTH) is derived, not overridable.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port wr_en  input  1  write one vector this cycle.
REQ-007 SHALL have port wr_addr  input  AW  write vector index.
REQ-008 SHALL have port wr_data_flat  input  SYSTOLIC_SIZE*ACTIVATION_WIDTH  write vector; lane i at bits [i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH].
REQ-009 SHALL have port start  input  1  request to stream vectors 0..length-1.
REQ-010 SHALL have port length  input  AW+1  number of vectors to stream, sampled with start.
REQ-011 SHALL have port activation_out_flat  output  SYSTOLIC_SIZE*ACTIVATION_WIDTH  registered vector to the activation buffer, same lane packing.
REQ-012 SHALL have port act_valid  output  1  activation_out_flat carries a stream or flush vector.
REQ-013 SHALL have port busy  output  1  high in STREAM and FLUSH.
REQ-014 SHALL have port done  output  1  single-cycle pulse at end of a run.

Function
REQ-015 SHALL implement states IDLE, STREAM, FLUSH, DONE, all output-affecting signals registered.
REQ-016 SHALL in IDLE, on start=1 with length>0, load activation_out_flat<=mem[0], act_valid<=1, rd_ptr<=1, and go to STREAM, so vector k appears k+1 cycles after the start cycle.
REQ-017 SHALL clamp length>DEPTH to DEPTH at sampling.
REQ-018 SHALL in STREAM output mem[rd_ptr] each cycle and increment rd_ptr, with no gaps, until exactly length vectors have been output.
REQ-019 SHALL after the last vector go to FLUSH when compiled in (REQ-030), else to DONE.
REQ-020 SHALL in FLUSH output all-zero vectors with act_valid=1 for exactly SYSTOLIC_SIZE-1 cycles, then go to DONE.
REQ-021 SHALL in DONE drive done=1, act_valid=0, activation_out_flat=0 for one cycle, then return to IDLE.
REQ-022 SHALL on start=1 with length=0 in IDLE go directly to DONE, with no act_valid cycle.
REQ-023 SHALL ignore start outside IDLE.
REQ-024 SHALL drive activation_out_flat=0 and act_valid=0 whenever no vector is being output.
REQ-025 SHALL accept writes in every state; a write and a stream read to the same address in the same cycle returns the old data (read-before-write).
REQ-026 SHALL leave rd_ptr unchanged by writes; streamed data reflects the memory contents at each read cycle.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, set state=IDLE, rd_ptr=0, count=0, activation_out_flat=0, act_valid=0, busy=0, done=0.
REQ-028 SHALL let reset asserted mid-STREAM or mid-FLUSH abort the run with no done pulse, and ignore wr_en while rst_n=0.
REQ-029 SHALL not reset memory contents.

Configuration
REQ-030 SHALL compile in the FLUSH state and its counter only when macro ACTIVATION_MEM_ZERO_FLUSH_EN is defined; with it, a run is length+SYSTOLIC_SIZE-1 valid cycles; without it, a run is length valid cycles, STREAM goes straight to DONE, and no flush logic exists.

Structure
REQ-031 SHALL take default SYSTOLIC_SIZE, ACTIVATION_WIDTH and the state encoding typedef from shared package strait_pkg.
REQ-032 SHALL place storage in sub-module activation_mem_array (1 write port, 1 synchronous read port, read-before-write); sequencing FSM stays in activation_mem.

Verification (SYSTOLIC_SIZE=8, ACTIVATION_WIDTH=8, DEPTH=16)
REQ-033 SHALL cover this case: write lane i of addr a = a*16+i for a=0..3, then start length=4 -> act_valid cycles 1-4 carry addr 0..3 in order, then 7 zero vectors, done at cycle 12, busy high cycles 1-11.
REQ-034 SHALL cover this case: start with length=0 -> done pulse at cycle 1, act_valid never high.
REQ-035 SHALL cover this case: start with length=20 -> exactly 16 stream vectors (addr 0..15), no wrap past 15.
REQ-036 SHALL cover this case: during STREAM, write addr 2=0xFF.. in the cycle addr 2 is read -> old addr-2 data output; a rerun then outputs 0xFF.
REQ-037 SHALL cover this case: second start pulse at cycle 3 of a run -> ignored, single done pulse; rst_n=0 at cycle 2 -> act_valid=0 and outputs 0 next cycle, no done.
REQ-038 SHALL cover this case: without ACTIVATION_MEM_ZERO_FLUSH_EN, length=4 -> done at cycle 5, no zero vectors.
